// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one full round per clock, 10 rounds, on-the-fly key expansion.
// Optional debug ports (round counter, round key) when AES128_SEQ_DBG_EN is defined.
module aes128_round_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES128_SEQ_DBG_EN
    output logic [3:0]   dbg_round,
    output logic [127:0] dbg_round_key,
`endif
    output logic         busy
);

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // a source holds valid and its data stable until that edge.

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_e;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset of entry b is 8*(255-b) = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte index is 4*col + row; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;

    logic [127:0] next_key;
    logic [127:0] sr_state;
    logic [127:0] round_out;
    logic         last_round;

    always_comb begin
        next_key   = key_expand(key_q, rcon_q);
        sr_state   = shift_rows(sub_bytes(data_q));
        last_round = (round_q == 4'd10);
        round_out  = (last_round ? sr_state : mix_columns(sr_state)) ^ next_key;
    end

    always_comb begin
        fsm_d       = fsm_q;
        data_d      = data_q;
        key_d       = key_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_data ^ in_key;
                    key_d   = in_key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = round_out;
                key_d  = next_key;
                rcon_d = xtime(rcon_q);
                if (last_round) begin
                    fsm_d       = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    out_valid_d = 1'b0;
                    round_d     = 4'd0;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        // Registered so ready stays low through reset and rises on the first edge after release.
        in_ready_d = (fsm_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            data_q      <= '0;
            key_q       <= '0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            key_q       <= key_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = (fsm_q != ST_IDLE);

`ifdef AES128_SEQ_DBG_EN
    assign dbg_round     = round_q;
    assign dbg_round_key = key_q;
`endif

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Directed bench for aes128_round_sequencer using FIPS-197 vectors, backpressure,
// mid-run reset, back-to-back and input-corruption scenarios.
module tb_aes128_round_sequencer;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;
`ifdef AES128_SEQ_DBG_EN
    logic [3:0]   dbg_round;
    logic [127:0] dbg_round_key;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    logic [127:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    aes128_round_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_key       (in_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
`ifdef AES128_SEQ_DBG_EN
        .dbg_round    (dbg_round),
        .dbg_round_key(dbg_round_key),
`endif
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every output handshake is compared against the oldest expected ciphertext
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("out_unexpected", 128'(exp_q.size() == 0), 128'd0);
            if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                        input bit push_exp, input string tag);
        bit rdy, accepted;
        if (push_exp) exp_q.push_back(ct);
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        accepted = 1'b0;
        for (int n = 0; n < 100 && !accepted; n++) begin
            rdy = in_ready;
            tick();
            accepted = rdy;
        end
        check_eq({tag, "_accept"}, 128'(accepted), 128'd1);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // inputs are scrambled every cycle while the block runs
    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 128'(lat), 128'd10);
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_post_busy"}, 128'(busy), 128'd0);
        check_eq({tag, "_post_ready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_vector(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] ct, input string tag);
        send(pt, key, ct, 1'b1, tag);
        check_eq({tag, "_busy"}, 128'(busy), 128'd1);
        check_eq({tag, "_ready_low"}, 128'(in_ready), 128'd0);
        wait_out(tag);
        finish_out(tag);
    endtask

    initial begin
        int chg, t1, t2;
        logic [127:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        tick();
        tick();
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_out_data", out_data, 128'd0);
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
`ifdef AES128_SEQ_DBG_EN
        check_eq("rst_dbg_round", 128'(dbg_round), 128'd0);
        check_eq("rst_dbg_key", dbg_round_key, 128'd0);
`endif
        rst_n = 1'b1;
        tick();
        check_eq("rel_in_ready", 128'(in_ready), 128'd1);

        run_vector(C1_PT, C1_KEY, C1_CT, "c1");
        run_vector(B_PT, B_KEY, B_CT, "appb");
        check_eq("idle_keeps_data", out_data, B_CT);
`ifdef AES128_SEQ_DBG_EN
        check_eq("appb_round_key10", dbg_round_key, B_RK10);
        check_eq("idle_dbg_round", 128'(dbg_round), 128'd0);
`endif

        // backpressure with a pending input held in DONE
        send(C1_PT, C1_KEY, C1_CT, 1'b1, "bp_a");
        wait_out("bp_a");
        in_valid = 1'b1; in_data = B_PT; in_key = B_KEY;
        held = out_data;
        chg = 0;
        repeat (20) begin
            tick();
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) chg++;
        end
        check_eq("bp_stable", 128'(chg), 128'd0);
        check_eq("bp_hold_data", out_data, C1_CT);
        exp_q.push_back(B_CT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_idle_valid", 128'(out_valid), 128'd0);
        check_eq("bp_idle_busy", 128'(busy), 128'd0);
        check_eq("bp_idle_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_b_accepted", 128'(busy), 128'd1);
        wait_out("bp_b");
        finish_out("bp_b");

        // reset around round 5 discards the block
        send(C1_PT, C1_KEY, C1_CT, 1'b0, "rst_mid");
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_eq("rst_mid_busy", 128'(busy), 128'd0);
        check_eq("rst_mid_valid", 128'(out_valid), 128'd0);
        check_eq("rst_mid_data", out_data, 128'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_mid_ready", 128'(in_ready), 128'd1);
        check_eq("rst_mid_idle", 128'(busy), 128'd0);
        run_vector(C1_PT, C1_KEY, C1_CT, "c1_after_rst");

        // back-to-back with out_ready tied high
        out_ready = 1'b1;
        send(C1_PT, C1_KEY, C1_CT, 1'b1, "b2b_a");
        t1 = acc_cyc;
        send(B_PT, B_KEY, B_CT, 1'b1, "b2b_b");
        t2 = acc_cyc;
        check_eq("b2b_spacing", 128'(t2 - t1), 128'd12);
        for (int n = 0; n < 40 && busy; n++) tick();
        tick();
        out_ready = 1'b0;
        check_eq("b2b_drained", 128'(busy), 128'd0);

        check_eq("exp_q_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/aes128_round_sequencer.md
# aes128_round_sequencer

Iterative AES-128 encryption engine controller: accepts a 128-bit plaintext and key over a valid/ready handshake, runs one full AES round per clock for 10 rounds, and presents the ciphertext over a second valid/ready handshake. It owns the round FSM, round counter, round-constant generator and on-the-fly key expansion. It sequences the combinational round stages (SubBytes, the existing `shift_rows` block, MixColumns, AddRoundKey) around a single 128-bit state register.

## Interface
Parameters: none; AES-128 only, 10 rounds fixed.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: plaintext/key pair is valid.
- `in_ready` out 1: block can accept a new pair.
- `in_data` in 128: plaintext, FIPS-197 byte order; `[127:120]` is byte 0 (row 0, col 0), column-major.
- `in_key` in 128: cipher key, same byte order.
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: downstream accepts ciphertext.
- `out_data` out 128: ciphertext, same byte order.
- `busy` out 1: high in RUN or DONE.

## Operation
FSM states: IDLE, RUN, DONE.

**IDLE**
- `in_ready` = 1.
- On `in_valid` = 1:
  - state register ← `in_data ^ in_key` (round 0 AddRoundKey).
  - round key register ← `in_key`.
  - round counter ← 1, rcon ← 0x01.
  - Go to RUN.

**RUN**
- `in_ready` = 0; inputs are ignored.
- Each cycle:
  - next_key = KeyExpand(round key, rcon), per FIPS-197 (RotWord, SubWord, XOR rcon into byte 0, chained XOR across words).
  - state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), next_key).
  - round key ← next_key; rcon ← xtime(rcon), i.e. 0x80 → 0x1B.
  - Counter increments.
- When counter = 10:
  - MixColumns is bypassed.
  - The result is written to the state register.
  - Go to DONE.

**DONE**
- `out_valid` = 1 and `out_data` = state register; both are stable until the handshake completes.
- On `out_ready` = 1: go to IDLE.
- The state register is not cleared; `out_data` retains the last ciphertext.

**Datapath and outputs**
- S-box: 20 combinational instances (16 state, 4 key), each a 256-entry constant table.
- `busy` = (state ≠ IDLE).

**Boundary cases**
- `out_ready` held low in DONE: stall indefinitely; `out_data` unchanged; no new acceptance.
- `in_valid` asserted during RUN/DONE: not accepted; the source must hold it until `in_ready`.
- `rst_n` low mid-RUN or in DONE: FSM → IDLE next edge; in-flight block discarded; no partial output.
- `in_data`/`in_key` changing during RUN: no effect on the result.

## Timing
**Reset** (on the clock edge where `rst_n` = 0):
- FSM = IDLE, counter = 0, rcon = 0x01, state and key registers = 0.
- `out_valid` = 0, `busy` = 0, `out_data` = 0.
- `in_ready` is forced to 0 while `rst_n` = 0, and is 1 from the first cycle after release.

**Latency**
- Acceptance edge E0 → `out_valid` high in the cycle after edge E10, i.e. 10 cycles after acceptance.

**Throughput**
- 12 edges per block with `out_ready` tied high: accept, 10 rounds, DONE handshake.
- A new block can be accepted only once the FSM is back in IDLE.

**Output signal types**
- `in_ready`, `busy`: decoded from registered FSM state; glitch-free relative to `clk`.
- `out_valid`: registered.
- No combinational path from any input to any output.

## Configuration
- `AES128_SEQ_DBG_EN` defined:
  - Adds output `dbg_round` [3:0]: the current round counter, 0 in IDLE, 1..10 in RUN, 10 in DONE.
  - Adds output `dbg_round_key` [127:0]: the current round-key register.
- Not defined: neither port exists. Functional behaviour and timing are identical either way.

## Test plan
- **FIPS-197 App. C.1:** key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → `out_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rises exactly 10 cycles after acceptance.
- **FIPS-197 App. B:** key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. With `AES128_SEQ_DBG_EN` defined, `dbg_round_key` after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Backpressure:** hold `out_ready` = 0 for 20 cycles in DONE with `in_valid` = 1 → `out_data` stable, `in_ready` = 0, no second acceptance. Releasing `out_ready` gives one handshake, then IDLE, then acceptance of the pending input one cycle later.
- **Reset mid-operation:** pulse `rst_n` low for 1 cycle at round 5 → next cycle IDLE, `out_valid` = 0, `busy` = 0, `in_ready` = 1. A subsequent C.1 vector still produces the correct ciphertext.
- **Back-to-back:** two C.1/App. B vectors queued with `out_ready` tied high → both ciphertexts correct and in order, acceptances 12 cycles apart.
- **Input corruption:** randomize `in_data`/`in_key` every cycle during RUN → ciphertext matches the values captured at acceptance.
